cpt_rr_sched: RTL and testbench

// Round-robin scheduler that time-slices one shared 3-bit counter (bit_cpt3-style datapath) among N requesters.

---
 rtl/cpt_rr_sched_if.sv | 37 +++
 rtl/cpt_rr_sched.sv | 148 ++++++++++++++
 tb/tb_cpt_rr_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpt_rr_sched_if.sv
// Client/counter-side bundle of the round-robin scheduler.
// master: the scheduler (drives grant and counter controls, samples req).
// slave : the client side (drives req, observes grant and counter state).
interface cpt_rr_sched_if #(
  parameter int N = 4,
  parameter int W = 3
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [PW-1:0] owner;
  logic          cpt_activate;
  logic          cpt_clear;
  logic [W-1:0]  cpt;
  logic          slice_done;

  modport master (
    input  req,
    output gnt,
    output owner,
    output cpt_activate,
    output cpt_clear,
    output cpt,
    output slice_done
  );

  modport slave (
    output req,
    input  gnt,
    input  owner,
    input  cpt_activate,
    input  cpt_clear,
    input  cpt,
    input  slice_done
  );
endinterface

// File: rtl/cpt_rr_sched.sv
// Round-robin scheduler time-slicing one shared W-bit counter among N clients.
// A grant lasts SLICE cycles unless the owner drops its request first; every
// grant is followed by a one-cycle SWITCH gap in which the shared counter is
// cleared. All outputs are registered.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | nobody owns the counter; arbitrate every edge
// GRANT  | one client owns the counter; cpt counts the slice
// SWITCH | one-cycle gap after a grant ends; counter held clear, then arbitrate
module cpt_rr_sched #(
  parameter int N     = 4,
  parameter int W     = 3,
  parameter int SLICE = 5
) (
  input logic             clk,
  input logic             reset,
  cpt_rr_sched_if.master  bus
);

  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int PW1 = PW + 1;
  localparam logic [PW-1:0] OWNER_LAST = PW'(N - 1);
  localparam logic [PW:0]   N_EXT      = PW1'(N);
  localparam logic [W-1:0]  CPT_LAST   = W'(SLICE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  cpt_q, cpt_d;
  logic          slice_done_q, slice_done_d;
  logic          cpt_activate_q, cpt_activate_d;
  logic          cpt_clear_q, cpt_clear_d;

  logic [N-1:0]  arb_rot;
  logic          arb_found;
  logic [PW-1:0] arb_off;
  logic [PW:0]   arb_sum;
  logic [PW-1:0] arb_idx;
  logic [N-1:0]  arb_gnt;
  logic          owner_live;
  logic [PW-1:0] ptr_after_owner;

  // Rotate req so bit 0 is the pointer position; the lowest set bit wins.
  always_comb begin
    arb_rot   = N'({bus.req, bus.req} >> ptr_q);
    arb_found = |arb_rot;
    arb_off   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (arb_rot[j]) arb_off = PW'(j);
    end
    arb_sum = {1'b0, ptr_q} + {1'b0, arb_off};
    if (arb_sum >= N_EXT) arb_sum = arb_sum - N_EXT;
    arb_idx = arb_sum[PW-1:0];
    arb_gnt = {{(N-1){1'b0}}, 1'b1} << arb_idx;
  end

  // Owner still requesting, and the pointer value to use once its grant ends.
  always_comb begin
    owner_live      = |(gnt_q & bus.req);
    ptr_after_owner = (owner_q == OWNER_LAST) ? '0 : owner_q + PW'(1);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    cpt_d        = cpt_q;
    slice_done_d = 1'b0;

    unique case (state_q)
      IDLE, SWITCH: begin
        cpt_d = '0;
        if (arb_found) begin
          state_d = GRANT;
          gnt_d   = arb_gnt;
          owner_d = arb_idx;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          owner_d = '0;
        end
      end
      GRANT: begin
        if (!owner_live || (cpt_q == CPT_LAST)) begin
          // Release wins over expiry, so slice_done only flags a true timeout.
          state_d      = SWITCH;
          gnt_d        = '0;
          owner_d      = '0;
          cpt_d        = '0;
          ptr_d        = ptr_after_owner;
          slice_done_d = owner_live;
        end else begin
          cpt_d = cpt_q + W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
        cpt_d   = '0;
      end
    endcase

    cpt_activate_d = |gnt_d;
    cpt_clear_d    = ~|gnt_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      owner_q        <= '0;
      ptr_q          <= '0;
      cpt_q          <= '0;
      slice_done_q   <= 1'b0;
      cpt_activate_q <= 1'b0;
      cpt_clear_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      owner_q        <= owner_d;
      ptr_q          <= ptr_d;
      cpt_q          <= cpt_d;
      slice_done_q   <= slice_done_d;
      cpt_activate_q <= cpt_activate_d;
      cpt_clear_q    <= cpt_clear_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.owner        = owner_q;
  assign bus.cpt          = cpt_q;
  assign bus.slice_done   = slice_done_q;
  assign bus.cpt_activate = cpt_activate_q;
  assign bus.cpt_clear    = cpt_clear_q;

endmodule

// File: tb/tb_cpt_rr_sched.sv
// Directed bench for cpt_rr_sched (N=4, W=3, SLICE=5). The driver applies one
// input vector per cycle and queues the hand-computed outputs expected after
// the following clock edge; a monitor pops and compares them, and also checks
// the grant/counter-control invariants every cycle.
module tb_cpt_rr_sched;

  typedef struct {
    logic [3:0] gnt;
    logic [2:0] cpt;
    logic       sd;
    logic [1:0] own;
    int         id;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   step_id;
  exp_t exp_q[$];

  cpt_rr_sched_if #(.N(4), .W(3)) bus ();

  cpt_rr_sched #(.N(4), .W(3), .SLICE(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int id, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, id, got, want);
    end
  endtask

  // Monitor: compare queued expectations and invariants after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("gnt",        e.id, int'(bus.gnt),        int'(e.gnt));
      cmp("cpt",        e.id, int'(bus.cpt),        int'(e.cpt));
      cmp("slice_done", e.id, int'(bus.slice_done), int'(e.sd));
      cmp("owner",      e.id, int'(bus.owner),      int'(e.own));
    end
    cmp("gnt_onehot0",  step_id, int'($countones(bus.gnt) <= 1), 1);
    cmp("activate",     step_id, int'(bus.cpt_activate), int'(|bus.gnt));
    cmp("clear",        step_id, int'(bus.cpt_clear),    int'(~|bus.gnt));
    cmp("cpt_range",    step_id, int'(bus.cpt <= 3'd4),  1);
  end

  // Apply one input vector and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] r, input logic rs,
                      input logic [3:0] g, input int c, input logic sd, input int own);
    exp_t e;
    @(negedge clk);
    step_id++;
    bus.req = r;
    reset   = rs;
    e.gnt = g;
    e.cpt = 3'(c);
    e.sd  = sd;
    e.own = 2'(own);
    e.id  = step_id;
    exp_q.push_back(e);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    step_id = 0;
    reset   = 1'b1;
    bus.req = 4'b0000;

    // 1: single client, expiry, re-grant after one gap cycle
    step(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 0);
    for (int c = 0; c < 5; c++) step(4'b0001, 1'b0, 4'b0001, c, 1'b0, 0);
    step(4'b0001, 1'b0, 4'b0000, 0, 1'b1, 0);
    step(4'b0001, 1'b0, 4'b0001, 0, 1'b0, 0);
    step(4'b0001, 1'b0, 4'b0001, 1, 1'b0, 0);

    // 2: all requesting, rotation 0,1,2,3,0 with wrap
    step(4'b1111, 1'b1, 4'b0000, 0, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 5; c++) step(4'b1111, 1'b0, 4'(1 << (k % 4)), c, 1'b0, k % 4);
      if (k < 4) step(4'b1111, 1'b0, 4'b0000, 0, 1'b1, 0);
    end

    // 3: owner 0 releases after cpt=2; client 1 is granted next
    step(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 0);
    for (int c = 0; c < 3; c++) step(4'b0001, 1'b0, 4'b0001, c, 1'b0, 0);
    step(4'b0010, 1'b0, 4'b0000, 0, 1'b0, 0);
    step(4'b0010, 1'b0, 4'b0010, 0, 1'b0, 1);

    // 4: owner 2 expires, req=0101 -> scan 3,0 picks client 0
    step(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 0);
    for (int c = 0; c < 5; c++) step(4'b0100, 1'b0, 4'b0100, c, 1'b0, 2);
    step(4'b0101, 1'b0, 4'b0000, 0, 1'b1, 0);
    step(4'b0101, 1'b0, 4'b0001, 0, 1'b0, 0);

    // 5: reset at cpt=3 aborts the grant and returns ptr to 0 (was 3)
    for (int c = 1; c < 4; c++) step(4'b0001, 1'b0, 4'b0001, c, 1'b0, 0);
    step(4'b0001, 1'b1, 4'b0000, 0, 1'b0, 0);
    step(4'b1010, 1'b0, 4'b0010, 0, 1'b0, 1);

    // 6: release on the same edge as expiry -> no slice_done
    step(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 0);
    for (int c = 0; c < 5; c++) step(4'b0001, 1'b0, 4'b0001, c, 1'b0, 0);
    step(4'b0000, 1'b0, 4'b0000, 0, 1'b0, 0);
    step(4'b0000, 1'b0, 4'b0000, 0, 1'b0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    cmp("queue_drained", step_id, exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
